mod_fixed_mul_iter: RTL and testbench

//  Sequential fixed-point multiplier, successor to the combinational fixed multiply.

---
 rtl/mod_fixed_mul_iter_pkg.sv | 39 +++
 rtl/mod_fixed_mul_iter_round_sat.sv | 25 ++
 rtl/mod_fixed_mul_iter.sv | 132 +++++++++++++
 tb/tb_mod_fixed_mul_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_fixed_mul_iter_pkg.sv
// rtl/mod_fixed_mul_iter_pkg.sv - shared state encoding and round/saturate helper for fixed-point multipliers
package pkg_fixed;
   localparam int MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } fixed_mul_state_e;

   // Returns {overflow, result[MAX_W-1:0]}; mag is the unsigned 2W-bit raw product.
   function automatic logic [MAX_W:0] fixed_round_sat(
      input logic [2*MAX_W-1:0] mag,
      input logic               sign,
      input int unsigned        w,
      input int unsigned        point,
      input logic               is_signed,
      input logic               round,
      input logic               sat
   );
      logic [2*MAX_W:0] r;
      logic [2*MAX_W:0] limit;
      logic [2*MAX_W:0] wmask;
      logic [MAX_W-1:0] v;
      logic             ovf;
      r = {1'b0, mag};
      if (round && point > 0) r = r + ((2*MAX_W+1)'(1) << (point - 1));
      r = r >> point;
      wmask = ((2*MAX_W+1)'(1) << w) - (2*MAX_W+1)'(1);
      // Negative results may reach one step further than positive ones.
      if (is_signed) limit = ((2*MAX_W+1)'(1) << (w - 1)) - {{(2*MAX_W){1'b0}}, ~sign};
      else           limit = wmask;
      ovf = r > limit;
      if (sat && ovf) r = limit;
      v = r[MAX_W-1:0] & wmask[MAX_W-1:0];
      if (sign) v = (~v + MAX_W'(1)) & wmask[MAX_W-1:0];
      return {ovf, v};
   endfunction
endpackage

// File: rtl/mod_fixed_mul_iter_round_sat.sv
// rtl/mod_fixed_mul_iter_round_sat.sv - combinational round, shift, saturate and sign stage
module mod_fixed_round_sat
   import pkg_fixed::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int INPUT_POINT = 8,
   parameter int SIGNED      = 1,
   parameter int ROUND       = 1,
   parameter int SATURATE    = 1
) (
   input  logic [2*INPUT_WIDTH-1:0] i_mag,
   input  logic                     i_sign,
   output logic [INPUT_WIDTH-1:0]   o_out,
   output logic                     o_overflow
);
   logic [MAX_W:0] res;

   always_comb begin
      res = fixed_round_sat((2*MAX_W)'(i_mag), i_sign, INPUT_WIDTH, INPUT_POINT,
                            SIGNED != 0, ROUND != 0, SATURATE != 0);
   end

   assign o_out      = INPUT_WIDTH'(res[MAX_W-1:0]);
   assign o_overflow = res[MAX_W];
endmodule

// File: rtl/mod_fixed_mul_iter.sv
// rtl/mod_fixed_mul_iter.sv - iterative shift-add fixed-point multiplier with trigger/ready handshake
module mod_fixed_mul_iter
   import pkg_fixed::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int INPUT_POINT = 8,
   parameter int DIGIT_BITS  = 1,
   parameter int SIGNED      = 1,
   parameter int ROUND       = 1,
   parameter int SATURATE    = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [INPUT_WIDTH-1:0] i_a,
   input  logic [INPUT_WIDTH-1:0] i_b,
   input  logic                   i_trigger,
   output logic [INPUT_WIDTH-1:0] o_out,
   output logic                   o_ready,
   output logic                   o_busy,
   output logic                   o_overflow
);
   localparam int W     = INPUT_WIDTH;
   localparam int W2    = 2 * INPUT_WIDTH;
   localparam int STEPS = INPUT_WIDTH / DIGIT_BITS;
   localparam int CW    = $clog2(STEPS + 1);
   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_CALC   = CALC;
   localparam logic [1:0] S_FINISH = FINISH;

   if (INPUT_WIDTH % DIGIT_BITS != 0 || INPUT_WIDTH > MAX_W || INPUT_POINT >= INPUT_WIDTH) begin : g_param_check
      $error("mod_fixed_mul_iter: illegal parameter combination");
   end

   logic [1:0]    state_q, state_d;
   logic [W2-1:0] acc_q, acc_d;
   logic [W2-1:0] mcand_q, mcand_d;
   logic [W-1:0]  b_mag_q, b_mag_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sign_q, sign_d;
   logic [W-1:0]  out_q, out_d;
   logic          ovf_q, ovf_d;
   logic          ready_q, ready_d;
   logic          a_neg, b_neg;
   logic [W-1:0]  a_abs, b_abs;
   logic [W-1:0]  rs_out;
   logic          rs_ovf;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      b_mag_d = b_mag_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      ready_d = 1'b0;
      a_neg   = (SIGNED != 0) && i_a[W-1];
      b_neg   = (SIGNED != 0) && i_b[W-1];
      a_abs   = a_neg ? -i_a : i_a;
      b_abs   = b_neg ? -i_b : i_b;
      case (state_q)
         S_IDLE: begin
            if (i_trigger) begin
               state_d = S_CALC;
               mcand_d = W2'(a_abs);
               b_mag_d = b_abs;
               acc_d   = '0;
               cnt_d   = CW'(STEPS);
               sign_d  = a_neg ^ b_neg;
            end
         end
         S_CALC: begin
            // One radix-2^DIGIT_BITS digit of the multiplier per cycle, LSB first.
            acc_d   = acc_q + mcand_q * W2'(b_mag_q[DIGIT_BITS-1:0]);
            mcand_d = mcand_q << DIGIT_BITS;
            b_mag_d = b_mag_q >> DIGIT_BITS;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            out_d   = rs_out;
            ovf_d   = rs_ovf;
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         b_mag_q <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         b_mag_q <= b_mag_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   mod_fixed_round_sat #(
      .INPUT_WIDTH(INPUT_WIDTH),
      .INPUT_POINT(INPUT_POINT),
      .SIGNED     (SIGNED),
      .ROUND      (ROUND),
      .SATURATE   (SATURATE)
   ) u_round_sat (
      .i_mag     (acc_q),
      .i_sign    (sign_q),
      .o_out     (rs_out),
      .o_overflow(rs_ovf)
   );

   assign o_out      = out_q;
   assign o_ready    = ready_q;
   assign o_busy     = (state_q != S_IDLE);
   assign o_overflow = ovf_q;
endmodule

// File: tb/tb_mod_fixed_mul_iter.sv
// tb/tb_mod_fixed_mul_iter.sv - bench for mod_fixed_mul_iter across four parameter sets
module tb_mod_fixed_mul_iter;
   // Instance 0: default; 1: truncate; 2: wrap; 3: radix-16 unsigned.
   localparam bit [3:0] CFG_S   = 4'b0111;
   localparam bit [3:0] CFG_R   = 4'b1101;
   localparam bit [3:0] CFG_SAT = 4'b1011;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [15:0]      a_in = '0;
   logic [15:0]      b_in = '0;
   logic             trig = 1'b0;
   logic [3:0][15:0] dout;
   logic [3:0]       drdy, dbusy, dovf;
   int               cyc = 0;
   int               rdy_cnt [4] = '{0, 0, 0, 0};
   int               rdy_cyc [4] = '{0, 0, 0, 0};
   int               total = 0;
   int               bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         if (drdy[i]) begin
            rdy_cnt[i] <= rdy_cnt[i] + 1;
            rdy_cyc[i] <= cyc;
         end
      end
   end

   mod_fixed_mul_iter #(.INPUT_WIDTH(16), .INPUT_POINT(8), .DIGIT_BITS(1), .SIGNED(1), .ROUND(1), .SATURATE(1)) u0 (
      .i_clk(clk), .i_rst(rst), .i_a(a_in), .i_b(b_in), .i_trigger(trig),
      .o_out(dout[0]), .o_ready(drdy[0]), .o_busy(dbusy[0]), .o_overflow(dovf[0]));
   mod_fixed_mul_iter #(.INPUT_WIDTH(16), .INPUT_POINT(8), .DIGIT_BITS(1), .SIGNED(1), .ROUND(0), .SATURATE(1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_a(a_in), .i_b(b_in), .i_trigger(trig),
      .o_out(dout[1]), .o_ready(drdy[1]), .o_busy(dbusy[1]), .o_overflow(dovf[1]));
   mod_fixed_mul_iter #(.INPUT_WIDTH(16), .INPUT_POINT(8), .DIGIT_BITS(1), .SIGNED(1), .ROUND(1), .SATURATE(0)) u2 (
      .i_clk(clk), .i_rst(rst), .i_a(a_in), .i_b(b_in), .i_trigger(trig),
      .o_out(dout[2]), .o_ready(drdy[2]), .o_busy(dbusy[2]), .o_overflow(dovf[2]));
   mod_fixed_mul_iter #(.INPUT_WIDTH(16), .INPUT_POINT(8), .DIGIT_BITS(4), .SIGNED(0), .ROUND(1), .SATURATE(1)) u3 (
      .i_clk(clk), .i_rst(rst), .i_a(a_in), .i_b(b_in), .i_trigger(trig),
      .o_out(dout[3]), .o_ready(drdy[3]), .o_busy(dbusy[3]), .o_overflow(dovf[3]));

   function automatic int steps_of(input int i);
      return (i == 3) ? 4 : 16;
   endfunction

   // Q8.8 product from plain integer arithmetic; returns {overflow, result}.
   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input bit s, input bit r, input bit sat);
      longint p, m, lim;
      bit     neg, ovf;
      logic [15:0] v;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      neg = (p < 0);
      m = neg ? -p : p;
      if (r) m = m + 128;
      m = m / 256;
      lim = s ? (neg ? 32768 : 32767) : 65535;
      ovf = (m > lim);
      if (sat && ovf) m = lim;
      v = m[15:0];
      if (neg) v = -v;
      return {ovf, v};
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b);
      int snap [4];
      int t0, n;
      logic [16:0] exp_v;
      for (int i = 0; i < 4; i++) snap[i] = rdy_cnt[i];
      a_in = a; b_in = b; trig = 1'b1; t0 = cyc;
      @(negedge clk);
      trig = 1'b0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      total++;
      if (dbusy !== 4'hF) begin
         bad++; $display("FAIL busy_after_trigger a=%h b=%h got=%b want=1111", a, b, dbusy);
      end
      n = 0;
      while (rdy_cnt[0] == snap[0] && n < 60) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         exp_v = model(a, b, CFG_S[i], CFG_R[i], CFG_SAT[i]);
         total++;
         if (rdy_cnt[i] !== snap[i] + 1) begin
            bad++; $display("FAIL ready_count u%0d a=%h b=%h got=%0d want=%0d", i, a, b, rdy_cnt[i] - snap[i], 1);
         end
         total++;
         if ({dovf[i], dout[i]} !== exp_v) begin
            bad++; $display("FAIL result u%0d a=%h b=%h got=%b/%h want=%b/%h", i, a, b, dovf[i], dout[i], exp_v[16], exp_v[15:0]);
         end
         total++;
         if (rdy_cyc[i] - t0 !== steps_of(i) + 2) begin
            bad++; $display("FAIL latency u%0d got=%0d want=%0d", i, rdy_cyc[i] - t0, steps_of(i) + 2);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({dout[i], drdy[i], dbusy[i], dovf[i]} !== 19'd0) begin
            bad++; $display("FAIL reset_state u%0d got out=%h rdy=%b busy=%b ovf=%b want all 0", i, dout[i], drdy[i], dbusy[i], dovf[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [15:0] ta [7] = '{16'h0180, 16'hFE80, 16'h0200, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
      logic [15:0] tb [7] = '{16'h0200, 16'h0200, 16'hFE80, 16'h0080, 16'h0080, 16'h7FFF, 16'h8000};
      logic [16:0] te [7] = '{17'h00300, 17'h0FD00, 17'h0FD00, 17'h00001, 17'h0FFFF, 17'h17FFF, 17'h17FFF};
      for (int k = 0; k < 7; k++) begin
         run_op(ta[k], tb[k]);
         total++;
         if ({dovf[0], dout[0]} !== te[k]) begin
            bad++; $display("FAIL directed_%0d got=%b/%h want=%b/%h", k, dovf[0], dout[0], te[k][16], te[k][15:0]);
         end
         if (k == 3) begin
            total++;
            if (dout[1] !== 16'h0000) begin
               bad++; $display("FAIL truncate_small got=%h want=0000", dout[1]);
            end
         end
         if (k == 5 || k == 6) begin
            total++;
            if ({dovf[2], dout[2]} !== ((k == 5) ? 17'h1FF00 : 17'h10000)) begin
               bad++; $display("FAIL wrap_%0d got=%b/%h want ovf=1", k, dovf[2], dout[2]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      for (int k = 0; k < 40; k++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (k % 2 == 0) begin
            a = 16'($urandom_range(0, 2047));
            b = 16'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         run_op(a, b);
      end
   endtask

   task automatic test_back_to_back();
      int snap [4];
      int t0;
      logic [16:0] exp_v;
      for (int i = 0; i < 4; i++) snap[i] = rdy_cnt[i];
      a_in = 16'hFD40; b_in = 16'h0150; trig = 1'b1; t0 = cyc;
      repeat (54) @(negedge clk);
      trig = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         exp_v = model(16'hFD40, 16'h0150, CFG_S[i], CFG_R[i], CFG_SAT[i]);
         total++;
         if (rdy_cnt[i] - snap[i] !== ((i == 3) ? 9 : 3)) begin
            bad++; $display("FAIL b2b_count u%0d got=%0d want=%0d", i, rdy_cnt[i] - snap[i], (i == 3) ? 9 : 3);
         end
         total++;
         if (rdy_cyc[i] - t0 !== 54) begin
            bad++; $display("FAIL b2b_last_ready u%0d got=%0d want=54", i, rdy_cyc[i] - t0);
         end
         total++;
         if ({dovf[i], dout[i]} !== exp_v) begin
            bad++; $display("FAIL b2b_result u%0d got=%b/%h want=%b/%h", i, dovf[i], dout[i], exp_v[16], exp_v[15:0]);
         end
      end
      total++;
      if (dbusy !== 4'h0) begin
         bad++; $display("FAIL b2b_idle got=%b want=0000", dbusy);
      end
   endtask

   task automatic test_abort();
      int snap [4];
      run_op(16'h0180, 16'h0200);
      for (int i = 0; i < 4; i++) snap[i] = rdy_cnt[i];
      a_in = 16'h0300; b_in = 16'h0400; trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({dout, drdy, dbusy, dovf} !== '0) begin
         bad++; $display("FAIL abort_outputs got out=%h rdy=%b busy=%b ovf=%b want all 0", dout, drdy, dbusy, dovf);
      end
      repeat (25) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rdy_cnt[i] !== snap[i]) begin
            bad++; $display("FAIL abort_no_ready u%0d got=%0d want=0", i, rdy_cnt[i] - snap[i]);
         end
      end
      run_op(16'hFF00, 16'h0300);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
